dma_write_scheduler: RTL
========================

# dma_write_scheduler

Job scheduler that shares one DMA AXI write engine among `NUM_CH` requesting channels. Each channel presents a 2-D transfer descriptor (base address, line size, line count, stride, increment mode). The scheduler arbitrates between channels, latches the winning descriptor and pulses the engine's start. It then holds the engine until completion and returns a per-channel done pulse. It sits between the DMA register bank and the write-channel engine.

## Interface
- `NUM_CH`, 4, number of requesting channels (2..8)
- `BW_ADDR`, 32, address/stride width
- `BW_LINE_SIZE`, 16, line-size width (bytes)
- `BW_NUM_LINES`, 16, line-count width
- `clk`  in  1  clock, all logic on rising edge
- `rstnn`  in  1  asynchronous active-low reset
- `enable`  in  1  1 = new grants allowed; 0 = finish in-flight job only
- `ch_req`  in  NUM_CH  level request per channel
- `ch_addr`  in  NUM_CH*BW_ADDR  flattened base addresses, channel i at [i*BW_ADDR +: BW_ADDR]
- `ch_line_size`  in  NUM_CH*BW_LINE_SIZE  flattened line sizes
- `ch_num_lines`  in  NUM_CH*BW_NUM_LINES  flattened line counts
- `ch_stride`  in  NUM_CH*BW_ADDR  flattened strides
- `ch_incr`  in  NUM_CH  1 = INCR burst, 0 = FIXED
- `ch_ack`  out  NUM_CH  one-cycle one-hot pulse: descriptor accepted
- `ch_done`  out  NUM_CH  one-cycle one-hot pulse: job complete
- `eng_start`  out  1  one-cycle start pulse to engine
- `eng_addr`, `eng_line_size`, `eng_num_lines`, `eng_stride`, `eng_incr`  out  per-field widths  latched descriptor, stable from `eng_start` until the done-consuming cycle
- `eng_done`  in  1  engine completion pulse (all W beats issued and strobe FIFO drained)
- `busy`  out  1  1 in any state other than IDLE
- `cur_ch`  out  clog2(NUM_CH)  index of the channel owning the engine

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If `enable` and `|ch_req`, select the winner (round-robin from `rr_ptr`).
  - On the same edge, latch the winner's descriptor into the `eng_*` registers, load `cur_ch`, and go to ISSUE.
- ISSUE, one cycle:
  - `eng_start`=1 and `ch_ack[cur_ch]`=1.
  - Next state is WAIT.
- WAIT:
  - On `eng_done`: `ch_done[cur_ch]`=1 this cycle, `rr_ptr` <= `cur_ch`+1 (mod NUM_CH), next state IDLE.
- Round-robin search:
  - Order is `rr_ptr`, `rr_ptr`+1, … wrapping at NUM_CH.
  - `rr_ptr` resets to 0 and is updated only at job completion.
- `ch_req` is level-sensitive. A channel still requesting when the scheduler re-enters IDLE is treated as a new job.
- Requesters must drop `req` by the cycle after their `ch_done`. Config inputs are don't-care after `ch_ack`.
- Request withdrawn after the latch edge: the job still runs to completion and done is still pulsed.
- `enable` low in ISSUE/WAIT: the current job completes normally and no new grant is made.
- `eng_done` outside WAIT (in IDLE or ISSUE) is ignored. It must not corrupt state.
- A descriptor with `num_lines`=0 or `line_size`=0 is still issued. Completion is owned by the engine.
- Reset mid-job:
  - All state returns to IDLE and all outputs go to reset values.
  - No `ch_done` is emitted for the aborted job.

## Timing
- Reset values:
  - `eng_start`, `ch_ack`, `ch_done`, `busy` = 0.
  - `eng_addr`, `eng_line_size`, `eng_num_lines`, `eng_stride`, `eng_incr`, `cur_ch` = 0.
- Request seen high in IDLE at edge N → `eng_start`/`ch_ack` high in cycle N+1.
- `eng_done` high in cycle M (in WAIT) → `ch_done` high in cycle M (combinational from registered state and `eng_done`) → IDLE at M+1 → next `eng_start` no earlier than M+2.
- `busy` goes high the cycle after the grant edge and low the cycle after `eng_done`.
- All outputs are registered except `ch_done`.

## Configuration
- `DMA_WRITE_SCHEDULER_FIXED_PRIORITY_EN`:
  - Defined: fixed priority; the lowest channel index wins, and `rr_ptr` is removed (permanently 0).
  - Undefined (default): round-robin as above.
- Handshake and timing are identical in both modes.

## Structure
- Shared package/header holds the state encoding (IDLE=0, ISSUE=1, WAIT=2, 2-bit) and the flattened-slice helper macros.
- One sub-module, `dma_write_scheduler_arbiter`:
  - Combinational rotate-priority select.
  - Inputs: `req`, `rr_ptr`. Outputs: `grant_valid`, `grant_idx`.
  - The fixed-priority macro is applied inside it.

## Test plan
- Single job: `ch_req`=4'b0010, `ch_addr`[1]=0x1000, `eng_done` 20 cycles after start → `eng_start` and `ch_ack`=4'b0010 one cycle after the request, `eng_addr`=0x1000, `ch_done`=4'b0010 in the `eng_done` cycle.
- Fairness: all four channels hold `ch_req`=4'b1111 and re-request after each done → grant order 0,1,2,3,0; with the fixed-priority macro defined, ch0 wins every time.
- Back-to-back: `eng_done` returned the cycle after `eng_start`, two channels requesting → second `eng_start` exactly 2 cycles after the first `ch_done`.
- Enable gating: `enable` dropped during WAIT with ch2 pending → current job completes, no `eng_start` until `enable`=1.
- Spurious done: `eng_done` pulsed in IDLE and in ISSUE → no `ch_done`, state unaffected, job still completes on a later `eng_done` in WAIT.
- Reset mid-job: `rstnn` low in WAIT → `busy`=0 and all `eng_*` fields 0 immediately; no `ch_done`; `rr_ptr`=0 after release.

Source files
------------

// File: rtl/dma_write_scheduler_pkg.sv
// Shared definitions for dma_write_scheduler: FSM state encoding and the
// helper macro that extracts one channel's field from a flattened bus.
// Optional build macro: DMA_WRITE_SCHEDULER_FIXED_PRIORITY_EN.

`ifndef DMA_WRITE_SCHEDULER_SLICE
`define DMA_WRITE_SCHEDULER_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package dma_write_scheduler_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/dma_write_scheduler_arbiter.sv
// Combinational channel selector for dma_write_scheduler.
// Default: rotating priority starting at rr_ptr.
// DMA_WRITE_SCHEDULER_FIXED_PRIORITY_EN defined: lowest index wins, rr_ptr ignored.

module dma_write_scheduler_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx
);

`ifdef DMA_WRITE_SCHEDULER_FIXED_PRIORITY_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Lowest requesting index wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (req[k] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(k);
      end
    end
  end
`else
  // First requester found scanning rr_ptr, rr_ptr+1, ... with wrap.
  always_comb begin
    int unsigned cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_CH;
      if (req[IDX_W'(cand)] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/dma_write_scheduler.sv
// Shares one DMA AXI write engine among NUM_CH channels: arbitrates, latches
// the winning 2-D descriptor, pulses eng_start/ch_ack, waits for eng_done and
// returns a combinational ch_done pulse in the same cycle.
// Optional build macro: DMA_WRITE_SCHEDULER_FIXED_PRIORITY_EN (fixed priority).

module dma_write_scheduler
  import dma_write_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned BW_ADDR      = 32,
  parameter int unsigned BW_LINE_SIZE = 16,
  parameter int unsigned BW_NUM_LINES = 16
) (
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           enable,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH*BW_ADDR-1:0]      ch_addr,
  input  logic [NUM_CH*BW_LINE_SIZE-1:0] ch_line_size,
  input  logic [NUM_CH*BW_NUM_LINES-1:0] ch_num_lines,
  input  logic [NUM_CH*BW_ADDR-1:0]      ch_stride,
  input  logic [NUM_CH-1:0]              ch_incr,
  output logic [NUM_CH-1:0]              ch_ack,
  output logic [NUM_CH-1:0]              ch_done,
  output logic                           eng_start,
  output logic [BW_ADDR-1:0]             eng_addr,
  output logic [BW_LINE_SIZE-1:0]        eng_line_size,
  output logic [BW_NUM_LINES-1:0]        eng_num_lines,
  output logic [BW_ADDR-1:0]             eng_stride,
  output logic                           eng_incr,
  input  logic                           eng_done,
  output logic                           busy,
  output logic [$clog2(NUM_CH)-1:0]      cur_ch
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  state_e             state, state_d;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic               grant_take;
  logic               job_end;

  logic [BW_ADDR-1:0]      addr_a      [NUM_CH];
  logic [BW_LINE_SIZE-1:0] line_size_a [NUM_CH];
  logic [BW_NUM_LINES-1:0] num_lines_a [NUM_CH];
  logic [BW_ADDR-1:0]      stride_a    [NUM_CH];

  // Unflatten per-channel descriptor fields.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_a[i]      = `DMA_WRITE_SCHEDULER_SLICE(ch_addr, i, BW_ADDR);
    assign line_size_a[i] = `DMA_WRITE_SCHEDULER_SLICE(ch_line_size, i, BW_LINE_SIZE);
    assign num_lines_a[i] = `DMA_WRITE_SCHEDULER_SLICE(ch_num_lines, i, BW_NUM_LINES);
    assign stride_a[i]    = `DMA_WRITE_SCHEDULER_SLICE(ch_stride, i, BW_ADDR);
  end

  dma_write_scheduler_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arbiter (
    .req         (ch_req),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state; eng_done is only honoured in WAIT.
  always_comb begin
    state_d    = state;
    grant_take = 1'b0;
    job_end    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && grant_valid) begin
          grant_take = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          job_end = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion pulse in the same cycle as eng_done.
  always_comb begin
    ch_done = '0;
    if (job_end) ch_done[cur_ch] = 1'b1;
  end

  // Registered handshake outputs and latched descriptor.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      eng_start     <= 1'b0;
      ch_ack        <= '0;
      busy          <= 1'b0;
      cur_ch        <= '0;
      eng_addr      <= '0;
      eng_line_size <= '0;
      eng_num_lines <= '0;
      eng_stride    <= '0;
      eng_incr      <= 1'b0;
    end else begin
      eng_start <= grant_take;
      ch_ack    <= grant_take ? (NUM_CH'(1) << grant_idx) : '0;
      busy      <= (state_d != ST_IDLE);
      if (grant_take) begin
        cur_ch        <= grant_idx;
        eng_addr      <= addr_a[grant_idx];
        eng_line_size <= line_size_a[grant_idx];
        eng_num_lines <= num_lines_a[grant_idx];
        eng_stride    <= stride_a[grant_idx];
        eng_incr      <= ch_incr[grant_idx];
      end
    end
  end

`ifdef DMA_WRITE_SCHEDULER_FIXED_PRIORITY_EN
  assign rr_ptr = '0;
`else
  // Round-robin pointer advances past the channel that just completed.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      rr_ptr <= '0;
    end else if (job_end) begin
      rr_ptr <= (cur_ch == IDX_W'(NUM_CH - 1)) ? '0 : cur_ch + IDX_W'(1);
    end
  end
`endif

endmodule
